wb_stage: RTL

Writeback stage of the five-stage pipelined CPU, consuming the outputs of the MEM/WB pipeline register. It decodes the instruction in W, selects the writeback value and destination, and owns the 32×32 general register file. The register file's two combinational read ports serve the decode stage with internal write-through bypass. Writeback address, data and enable are exported to the hazard/forwarding unit, and a retired-instruction counter is maintained.

---
 rtl/wb_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: decodes the W instruction, owns the 32x32 register file with
// bypassed decode reads, and counts retired instructions. Optional trace: WB_TRACE_EN.
module wb_stage #(
  parameter logic [31:0] INIT_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic [31:0] w_pc,
  input  logic [31:0] w_instr,
  input  logic [31:0] w_memRd,
  input  logic [31:0] w_aluResult,
  input  logic [31:0] w_extImm,
  input  logic [4:0]  d_ra1,
  input  logic [4:0]  d_ra2,
  output logic [31:0] d_rd1,
  output logic [31:0] d_rd2,
  output logic        w_we,
  output logic [4:0]  w_wa,
  output logic [31:0] w_wd,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    K_NONE,
    K_RTYPE_ALU,
    K_ITYPE_ALU,
    K_LOAD,
    K_LUI,
    K_JAL
  } wb_kind_e;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;

  logic [5:0]  op;
  logic [5:0]  funct;
  wb_kind_e    kind;
  logic        dec_write;
  logic [31:0] grf [32];
  logic [31:0] retired_q;

  assign op    = w_instr[31:26];
  assign funct = w_instr[5:0];

  always_comb begin
    kind = K_NONE;
    case (op)
      OP_RTYPE: if (funct == FUNCT_ADD || funct == FUNCT_SUB) kind = K_RTYPE_ALU;
      OP_ORI:   kind = K_ITYPE_ALU;
      OP_LW:    kind = K_LOAD;
      OP_LUI:   kind = K_LUI;
      OP_JAL:   kind = K_JAL;
      default:  kind = K_NONE;
    endcase
  end

  // Non-writing encodings (sw, beq, jr, nop, unknown) present all-zero writeback fields.
  always_comb begin
    dec_write = 1'b0;
    w_wa      = 5'd0;
    w_wd      = 32'd0;
    case (kind)
      K_RTYPE_ALU: begin
        dec_write = 1'b1;
        w_wa      = w_instr[15:11];
        w_wd      = w_aluResult;
      end
      K_ITYPE_ALU: begin
        dec_write = 1'b1;
        w_wa      = w_instr[20:16];
        w_wd      = w_aluResult;
      end
      K_LOAD: begin
        dec_write = 1'b1;
        w_wa      = w_instr[20:16];
        w_wd      = w_memRd;
      end
      K_LUI: begin
        dec_write = 1'b1;
        w_wa      = w_instr[20:16];
        w_wd      = w_extImm;
      end
      K_JAL: begin
        dec_write = 1'b1;
        w_wa      = 5'd31;
        w_wd      = w_pc + 32'd8;
      end
      default: begin
        dec_write = 1'b0;
      end
    endcase
  end

  assign w_we = dec_write & ~halt & (w_wa != 5'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) grf[i] <= 32'd0;
    end else if (w_we) begin
      grf[w_wa] <= w_wd;
    end
  end

  // Write-through bypass lets decode see the value committing at this edge.
  always_comb begin
    d_rd1 = 32'd0;
    if (d_ra1 != 5'd0) begin
      if (w_we && d_ra1 == w_wa) d_rd1 = w_wd;
      else                       d_rd1 = grf[d_ra1];
    end
  end

  always_comb begin
    d_rd2 = 32'd0;
    if (d_ra2 != 5'd0) begin
      if (w_we && d_ra2 == w_wa) d_rd2 = w_wd;
      else                       d_rd2 = grf[d_ra2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= 32'd0;
    end else if (!halt && w_instr != 32'd0) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired = retired_q;

  logic unused_ok;
  assign unused_ok = ^{w_instr[25:21], w_instr[10:6], INIT_PC};

`ifdef WB_TRACE_EN
  always @(posedge clk) begin
    if (w_we) $display("%d@%h: $%d <= %h", $time, w_pc, w_wa, w_wd);
  end
`endif

endmodule
